id_control_seq: RTL and testbench
=================================

Name: id_control_seq

Overview:
- Next-generation ID-stage control unit: decodes mode/opcode/S into EXE/MEM/WB control and registers it into the ID/EX boundary (1-cycle latency).
- Adds block transfers (mode 2'b11, LDM/STM-style): a sequencer expands one instruction into one memory beat per set register-list bit, holding the front end via busy.
- Honours pipeline stall and flush.

Parameters:
- NUM_REGS, 16, register-list width and register-file size.
- EXE_CMD_W, 4, width of the execute command.
- OFS_W, 5, width of the word-offset output; must satisfy 2^OFS_W >= NUM_REGS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- mode  in  2  00 data-proc, 01 LDR/STR, 10 branch, 11 block transfer.
- opcode  in  4  data-proc opcode.
- s_bit  in  1  S flag for data-proc; L flag (1=load) for modes 01/11.
- reg_list  in  NUM_REGS  block-transfer register list.
- stall  in  1  hazard stall from hazard unit.
- flush  in  1  branch-taken flush.
- in_ready  out  1  !busy && !stall (combinational).
- busy  out  1  sequencer expanding a block (registered).
- out_valid  out  1  control outputs valid this cycle.
- exe_cmd  out  EXE_CMD_W  ALU command.
- mem_read, mem_write, wb_en, branch, status_update  out  1 each.
- reg_idx  out  $clog2(NUM_REGS)  transfer register for the current beat.
- ofs  out  OFS_W  word offset of the beat (0,1,2,...).
- last  out  1  final beat of the instruction (1 for all non-block instructions).

Behaviour:
- Reset (async, rst=1): state IDLE.
  - All outputs 0 except in_ready=1: out_valid, exe_cmd, mem_*, wb_en, branch, status_update, reg_idx, ofs, last, busy.
  - Remaining-mask and beat counter cleared.
  - Reset mid-block abandons the block.
- Priority each edge: flush > stall > normal.
- flush:
  - Output register becomes a bubble: out_valid=0 and all control bits 0.
  - State goes to IDLE, remaining mask cleared, busy=0.
  - An instruction presented in the same cycle is dropped.
- stall (no flush): output register, state, mask and counter all hold; no instruction accepted.
- IDLE, in_valid=1 and accepted: the registered outputs next cycle are:
  - Mode 00 data-proc, wb_en=1 except for CMP/TST:
    - MOV(1101)->0001, MVN(1111)->1001, ADD(0100)->0010, ADC(0101)->0011, SUB(0010)->0100, SBC(0110)->0101.
    - AND(0000)->0110, ORR(1100)->0111, EOR(0001)->1000.
    - CMP(1010)->0100 with wb_en=0, TST(1000)->0110 with wb_en=0.
    - Other opcodes: exe_cmd 0, wb_en 0, out_valid 1.
    - status_update = 1 for CMP/TST, else s_bit.
  - Mode 01: exe_cmd 0010. Load gives mem_read=wb_en=1; store gives mem_write=1. status_update 0.
  - Mode 10: branch=1, exe_cmd 0, status_update 0.
  - Mode 11:
    - First beat uses the lowest set bit: reg_idx=that index, ofs=0, exe_cmd 0010, load/store controls as mode 01.
    - If further bits remain, the remaining mask = reg_list minus that bit, state goes to BLOCK, busy=1, last=0. Otherwise last=1 and state stays IDLE.
    - reg_list==0: one beat with out_valid=1, all control bits 0, last=1.
  - In all cases out_valid=1 and last=1 unless stated otherwise.
- IDLE, in_valid=0: bubble (out_valid=0, control bits 0).
- BLOCK, per unstalled cycle:
  - Emit the lowest set bit of the remaining mask; ofs increments by 1; L is held from the accepted instruction.
  - When this beat clears the mask: last=1, state goes to IDLE, busy=0 from the next cycle.
  - in_valid is ignored while busy.
- A block of N set bits occupies exactly N unstalled cycles; ofs runs 0..N-1 with no wrap for N <= NUM_REGS.
- Stall in BLOCK repeats the held beat unchanged. Flush in BLOCK abandons the remaining beats.

Decomposition:
- Shared package arm_ctrl_pkg holds:
  - Mode constants (MODE_DP, MODE_MEM, MODE_BR, MODE_BLK).
  - Opcode constants (OP_MOV ... OP_TST).
  - EXE_CMD constants (EXE_MOV=0001 ... EXE_EOR=1000).
- One sub-module, lowest_set_enc, parametrised by NUM_REGS: returns the index of the lowest set bit plus a found flag, purely combinational.
- Decode is a combinational function inside the top; the sequencer and output register live in the top.

Test Plan:
- Reset then ADD (mode 00, opcode 0100, s=1) -> next cycle out_valid=1, exe_cmd=0010, wb_en=1, status_update=1, last=1.
- CMP with s=0 -> exe_cmd=0100, wb_en=0, status_update=1. MOV with s=0 -> exe_cmd=0001, status_update=0.
- Block load, reg_list=16'h8105 -> four beats: reg_idx 0,2,8,15, ofs 0..3, mem_read=wb_en=1 each, last only on beat 4. busy high during beats 2..4 (the cycles after beat 1), in_ready=0 throughout busy.
- Block store 16'h0006 with stall asserted two cycles on beat 1 -> beat (reg_idx 1, ofs 0, mem_write=1) held 3 cycles, then reg_idx 2, ofs 1, last=1.
- Block load 16'h00F0 with flush on beat 2 -> next cycle out_valid=0, busy=0, in_ready=1; the next instruction is accepted normally.
- rst asserted mid-block (async, between edges) -> all outputs 0 immediately; reg_list=0 block after reset -> a single all-zero beat, out_valid=1, last=1.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared ARM-style ID-stage constants: instruction modes, data-proc opcodes,
// execute commands, sequencer states and the decoded control bundle.
package arm_ctrl_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_BLK = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef enum logic {ST_IDLE, ST_BLOCK} state_t;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       status_update;
  } ctrl_t;

endpackage

// File: rtl/lowest_set_enc.sv
// Combinational priority encoder: index of the lowest set bit of vec,
// with found=0 (and idx=0) when vec is all zeros.
module lowest_set_enc #(
  parameter int NUM_REGS = 16,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] vec,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_control_seq.sv
// ID-stage control: decodes mode/opcode/S into registered EXE/MEM/WB controls
// and expands block transfers into one memory beat per register-list bit.
//
//   state    | meaning
//   ST_IDLE  | accepting new instructions (single-beat or first block beat)
//   ST_BLOCK | emitting remaining block beats, front end held via busy
module id_control_seq
  import arm_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int EXE_CMD_W = 4,
  parameter int OFS_W     = 5,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [3:0]           opcode,
  input  logic                 s_bit,
  input  logic [NUM_REGS-1:0]  reg_list,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_en,
  output logic                 branch,
  output logic                 status_update,
  output logic [IDX_W-1:0]     reg_idx,
  output logic [OFS_W-1:0]     ofs,
  output logic                 last
);

  function automatic ctrl_t decode(input logic [1:0] m, input logic [3:0] op, input logic s);
    ctrl_t c;
    c = '0;
    case (m)
      MODE_DP: begin
        c.wb_en         = 1'b1;
        c.status_update = s;
        case (op)
          OP_MOV:  c.exe_cmd = EXE_MOV;
          OP_MVN:  c.exe_cmd = EXE_MVN;
          OP_ADD:  c.exe_cmd = EXE_ADD;
          OP_ADC:  c.exe_cmd = EXE_ADC;
          OP_SUB:  c.exe_cmd = EXE_SUB;
          OP_SBC:  c.exe_cmd = EXE_SBC;
          OP_AND:  c.exe_cmd = EXE_AND;
          OP_ORR:  c.exe_cmd = EXE_ORR;
          OP_EOR:  c.exe_cmd = EXE_EOR;
          OP_CMP:  begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b0; c.status_update = 1'b1; end
          OP_TST:  begin c.exe_cmd = EXE_AND; c.wb_en = 1'b0; c.status_update = 1'b1; end
          default: c.wb_en = 1'b0;
        endcase
      end
      MODE_MEM, MODE_BLK: begin
        c.exe_cmd   = EXE_ADD;
        c.mem_read  = s;
        c.wb_en     = s;
        c.mem_write = ~s;
      end
      default: c.branch = 1'b1;
    endcase
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [OFS_W-1:0]    cnt_q, cnt_d;
  logic                load_q, load_d;
  logic                valid_q, valid_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic                last_q, last_d;

  logic [NUM_REGS-1:0] enc_vec, rem;
  logic [IDX_W-1:0]    low_idx;
  logic                low_found;

  assign enc_vec = (state_q == ST_BLOCK) ? mask_q : reg_list;
  assign rem     = enc_vec & ~(NUM_REGS'(1) << low_idx);

  lowest_set_enc #(.NUM_REGS(NUM_REGS)) u_enc (
    .vec   (enc_vec),
    .idx   (low_idx),
    .found (low_found)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    ofs_d   = ofs_q;
    last_d  = last_q;
    if (flush || (!stall && state_q == ST_IDLE && !in_valid)) begin
      state_d = ST_IDLE;
      mask_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ctrl_d  = '0;
      idx_d   = '0;
      ofs_d   = '0;
      last_d  = 1'b0;
    end else if (!stall) begin
      valid_d = 1'b1;
      if (state_q == ST_BLOCK) begin
        ctrl_d = decode(MODE_BLK, 4'b0000, load_q);
        idx_d  = low_idx;
        ofs_d  = cnt_q;
        cnt_d  = cnt_q + OFS_W'(1);
        mask_d = rem;
        last_d = (rem == '0);
        if (rem == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end else begin
        ctrl_d = decode(mode, opcode, s_bit);
        idx_d  = '0;
        ofs_d  = '0;
        last_d = 1'b1;
        mask_d = '0;
        cnt_d  = '0;
        if (mode == MODE_BLK) begin
          if (!low_found) begin
            ctrl_d = '0;
          end else begin
            idx_d = low_idx;
            if (rem != '0) begin
              state_d = ST_BLOCK;
              mask_d  = rem;
              cnt_d   = OFS_W'(1);
              load_d  = s_bit;
              last_d  = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      idx_q   <= '0;
      ofs_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      ofs_q   <= ofs_d;
      last_q  <= last_d;
    end
  end

  assign busy          = (state_q == ST_BLOCK);
  assign in_ready      = !busy && !stall;
  assign out_valid     = valid_q;
  assign exe_cmd       = EXE_CMD_W'(ctrl_q.exe_cmd);
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign wb_en         = ctrl_q.wb_en;
  assign branch        = ctrl_q.branch;
  assign status_update = ctrl_q.status_update;
  assign reg_idx       = idx_q;
  assign ofs           = ofs_q;
  assign last          = last_q;

endmodule

// File: tb/tb_id_control_seq.sv
// Scenario bench for id_control_seq: each test pushes the expected registered
// outputs for a cycle, drives that cycle, then pops and compares.
module tb_id_control_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  opcode = 4'b0000;
  logic        s_bit = 1'b0;
  logic [15:0] reg_list = 16'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_ready, busy, out_valid;
  logic [3:0]  exe_cmd;
  logic        mem_read, mem_write, wb_en, branch, status_update;
  logic [3:0]  reg_idx;
  logic [4:0]  ofs;
  logic        last;

  int total = 0;
  int bad   = 0;

  id_control_seq #(.NUM_REGS(16), .EXE_CMD_W(4), .OFS_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .opcode(opcode),
    .s_bit(s_bit), .reg_list(reg_list), .stall(stall), .flush(flush),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .exe_cmd(exe_cmd),
    .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .branch(branch),
    .status_update(status_update), .reg_idx(reg_idx), .ofs(ofs), .last(last)
  );

  always #5 clk = ~clk;

  // ctl field order: {mem_read, mem_write, wb_en, branch, status_update}
  typedef struct packed {
    logic       ov;
    logic [3:0] exe;
    logic [4:0] ctl;
    logic [3:0] idx;
    logic [4:0] ofs;
    logic       last;
    logic       busy;
    logic       ready;
  } obs_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  m;
    logic [3:0]  op;
    logic        s;
    logic [15:0] rl;
    logic        st;
    logic        fl;
  } stim_t;

  localparam logic [4:0] C_LD = 5'b10100;
  localparam logic [4:0] C_ST = 5'b01000;
  localparam obs_t BUBBLE  = 22'h000001;
  localparam stim_t IDLE_S = '0;

  obs_t sb[$];

  function automatic obs_t mk(input logic ov, input logic [3:0] exe, input logic [4:0] ctl,
                              input logic [3:0] idx, input logic [4:0] o,
                              input logic l, input logic b, input logic r);
    obs_t x;
    x = {ov, exe, ctl, idx, o, l, b, r};
    return x;
  endfunction

  function automatic stim_t sd(input logic v, input logic [1:0] m, input logic [3:0] op,
                               input logic s, input logic [15:0] rl,
                               input logic st, input logic fl);
    stim_t x;
    x = {v, m, op, s, rl, st, fl};
    return x;
  endfunction

  function automatic obs_t observe();
    obs_t x;
    x = {out_valid, exe_cmd, mem_read, mem_write, wb_en, branch, status_update,
         reg_idx, ofs, last, busy, in_ready};
    return x;
  endfunction

  task automatic tick(input stim_t s);
    @(negedge clk);
    in_valid = s.v;  mode = s.m;   opcode = s.op; s_bit = s.s;
    reg_list = s.rl; stall = s.st; flush = s.fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(BUBBLE);
    got = observe(); e = sb.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset got=%h exp=%h", got, e); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    stim_t s[13];
    obs_t  x[13];
    obs_t  got, e;
    s[0]  = sd(1, 2'b00, 4'b0100, 1, 0, 0, 0); x[0]  = mk(1, 4'h2, 5'b00101, 0, 0, 1, 0, 1);
    s[1]  = sd(1, 2'b00, 4'b1010, 0, 0, 0, 0); x[1]  = mk(1, 4'h4, 5'b00001, 0, 0, 1, 0, 1);
    s[2]  = sd(1, 2'b00, 4'b1101, 0, 0, 0, 0); x[2]  = mk(1, 4'h1, 5'b00100, 0, 0, 1, 0, 1);
    s[3]  = sd(1, 2'b00, 4'b1111, 1, 0, 0, 0); x[3]  = mk(1, 4'h9, 5'b00101, 0, 0, 1, 0, 1);
    s[4]  = sd(1, 2'b00, 4'b1000, 0, 0, 0, 0); x[4]  = mk(1, 4'h6, 5'b00001, 0, 0, 1, 0, 1);
    s[5]  = sd(1, 2'b00, 4'b0001, 0, 0, 0, 0); x[5]  = mk(1, 4'h8, 5'b00100, 0, 0, 1, 0, 1);
    s[6]  = sd(1, 2'b00, 4'b0011, 1, 0, 0, 0); x[6]  = mk(1, 4'h0, 5'b00001, 0, 0, 1, 0, 1);
    s[7]  = sd(1, 2'b01, 4'b0000, 1, 0, 0, 0); x[7]  = mk(1, 4'h2, C_LD,     0, 0, 1, 0, 1);
    s[8]  = sd(1, 2'b01, 4'b0100, 0, 0, 0, 0); x[8]  = mk(1, 4'h2, C_ST,     0, 0, 1, 0, 1);
    s[9]  = sd(1, 2'b10, 4'b0100, 1, 0, 0, 0); x[9]  = mk(1, 4'h0, 5'b00010, 0, 0, 1, 0, 1);
    s[10] = IDLE_S;                            x[10] = BUBBLE;
    s[11] = sd(1, 2'b00, 4'b0100, 1, 0, 1, 0); x[11] = 22'h000000;
    s[12] = IDLE_S;                            x[12] = BUBBLE;
    for (int i = 0; i < 13; i++) begin
      sb.push_back(x[i]);
      tick(s[i]);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL decode[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_block_load();
    stim_t mov_s;
    obs_t  x[5];
    obs_t  got, e;
    mov_s = sd(1, 2'b00, 4'b1101, 1, 0, 0, 0);
    x[0] = mk(1, 4'h2, C_LD, 4'd0,  5'd0, 0, 1, 0);
    x[1] = mk(1, 4'h2, C_LD, 4'd2,  5'd1, 0, 1, 0);
    x[2] = mk(1, 4'h2, C_LD, 4'd8,  5'd2, 0, 1, 0);
    x[3] = mk(1, 4'h2, C_LD, 4'd15, 5'd3, 1, 0, 1);
    x[4] = BUBBLE;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(x[i]);
      if (i == 0)      tick(sd(1, 2'b11, 4'b0000, 1, 16'h8105, 0, 0));
      else if (i < 4)  tick(mov_s);
      else             tick(IDLE_S);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL blk_load[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_block_stall();
    stim_t s[5];
    obs_t  x[5];
    obs_t  got, e;
    s[0] = sd(1, 2'b11, 4'b0000, 0, 16'h0006, 0, 0); x[0] = mk(1, 4'h2, C_ST, 1, 0, 0, 1, 0);
    s[1] = sd(0, 2'b00, 4'b0000, 0, 0, 1, 0);        x[1] = x[0];
    s[2] = s[1];                                     x[2] = x[0];
    s[3] = IDLE_S;                                   x[3] = mk(1, 4'h2, C_ST, 2, 1, 1, 0, 1);
    s[4] = IDLE_S;                                   x[4] = BUBBLE;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(x[i]);
      tick(s[i]);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL blk_stall[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_flush();
    stim_t s[6];
    obs_t  x[6];
    obs_t  got, e;
    s[0] = sd(1, 2'b11, 4'b0000, 1, 16'h00F0, 0, 0); x[0] = mk(1, 4'h2, C_LD, 4, 0, 0, 1, 0);
    s[1] = IDLE_S;                                   x[1] = mk(1, 4'h2, C_LD, 5, 1, 0, 1, 0);
    s[2] = sd(0, 2'b00, 4'b0000, 0, 0, 0, 1);        x[2] = BUBBLE;
    s[3] = sd(1, 2'b00, 4'b0100, 0, 0, 0, 0);        x[3] = mk(1, 4'h2, 5'b00100, 0, 0, 1, 0, 1);
    s[4] = sd(1, 2'b00, 4'b1101, 1, 0, 0, 1);        x[4] = BUBBLE;
    s[5] = IDLE_S;                                   x[5] = BUBBLE;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(x[i]);
      tick(s[i]);
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL flush[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(mk(1, 4'h2, C_ST, 4'(i), 5'(i), (i == 15), (i < 15), (i == 15)));
      else        sb.push_back(mk(1, 4'h1, 5'b00101, 0, 0, 1, 0, 1));
      if (i == 0) tick(sd(1, 2'b11, 4'b0000, 0, 16'hFFFF, 0, 0));
      else        tick(sd(1, 2'b00, 4'b1101, 1, 0, 0, 0));
      got = observe(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL full_list[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_reset_mid_block();
    obs_t got, e;
    sb.push_back(mk(1, 4'h2, C_LD, 8, 0, 0, 1, 0));
    tick(sd(1, 2'b11, 4'b0000, 1, 16'h0F00, 0, 0));
    got = observe(); e = sb.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_pre got=%h exp=%h", got, e); end
    #2;
    in_valid = 1'b0; mode = 2'b00; reg_list = 16'h0;
    rst = 1'b1;
    sb.push_back(BUBBLE);
    #1;
    got = observe(); e = sb.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_async got=%h exp=%h", got, e); end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(1, 4'h0, 5'b00000, 0, 0, 1, 0, 1));
    tick(sd(1, 2'b11, 4'b0000, 1, 16'h0000, 0, 0));
    got = observe(); e = sb.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL empty_list got=%h exp=%h", got, e); end
    sb.push_back(BUBBLE);
    tick(IDLE_S);
    got = observe(); e = sb.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL empty_after got=%h exp=%h", got, e); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_block_load();
    test_block_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
